wb_spi_master: RTL and testbench
================================

Name: wb_spi_master

Overview:
Wishbone classic slave SPI master (8-bit frames, modes 0-3) on the picorv32_wb_soc peripheral bus.
Drives the UEXT0 SPI pins (SCK, MOSI, SSEL, MISO) in hardware, replacing the bit-banged GPIO0[3:0] path.
Runs on wb_clk (24 MHz on DE10-Nano); the default divider gives about a 1 MHz SCK.

Parameters:
DIV_WIDTH, 16, width of the half-period divider field.
DEFAULT_DIV, 11, reset value of the divider; half-period = (DIV+1) wb_clk cycles.

Ports:
wb_clk  in  1  system clock
wb_rst  in  1  synchronous, active-high reset
wb_adr_i  in  4  byte address; only [3:2] decoded
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte-lane enables
wb_we_i  in  1  write enable
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_dat_o  out  32  read data
wb_ack_o  out  1  acknowledge
spi_sck_o  out  1  serial clock
spi_mosi_o  out  1  master out
spi_miso_i  in  1  master in
spi_ssel_o  out  1  slave select, software-driven level
irq_o  out  1  level interrupt

Behaviour:
- Interface: one clock, wb_clk. Reset wb_rst is synchronous and active-high.
- Reset values: wb_ack_o=0, wb_dat_o=0, spi_sck_o=0, spi_mosi_o=0, spi_ssel_o=1, irq_o=0. CTRL=DEFAULT_DIV | (1<<18). STATUS=0. RX=0. FSM in IDLE.
- Bus timing:
  - wb_ack_o asserts the cycle after cyc&stb&!ack is sampled; it is a 1-cycle pulse; no wait states.
  - The register side effect happens in the sampling cycle.
  - Writes honour wb_sel_i per byte lane.
- Register 0x0 DATA:
  - Write when busy=0: latches wb_dat_i[7:0] and starts a transfer.
  - Write when busy=1: data ignored, STATUS.ovr set (sticky).
  - Read: returns {24'b0, RX}; clears rxv.
- Register 0x4 CTRL:
  - Bits: [DIV_WIDTH-1:0] div, [16] cpol, [17] cpha, [18] ssel, [19] irq_en.
  - div, cpol and cpha are copied into a shadow at transfer start, so writes during a transfer do not affect it.
  - ssel drives spi_ssel_o the cycle after the write.
  - When idle, spi_sck_o=cpol the cycle after the CTRL write.
- Register 0x8 STATUS:
  - Bits: [0] busy (read-only), [1] rxv (read-only), [2] ovr.
  - Writing 1 to bit 2 clears ovr.
- Register 0xC: reads 0, writes ignored.
- FSM:
  - IDLE -> SHIFT on an accepted DATA write; busy=1 from the next cycle.
  - SHIFT: 16 SCK edges, one per (div+1) cycles, edge index e=0..15; SCK toggles on each edge.
  - CPHA=0: MOSI=bit7 on entry; even edges sample MISO; odd edges (except e=15) present the next bit.
  - CPHA=1: even edges present the next bit (starting with bit7); odd edges sample MISO.
  - Shift order is MSB first. After e=15, SCK equals cpol.
  - SHIFT -> GUARD: one half-period with no toggle.
  - GUARD -> IDLE: RX <= shifter, rxv=1, busy=0.
  - busy stays high for exactly 17*(div+1) cycles.
  - In IDLE, MOSI holds its last value.
- div=0 gives SCK = wb_clk/2. div counter wrap is modulo (div+1); no other wrap case.
- Simultaneous DATA read and completion: read returns the old RX; rxv ends at 1 (set wins).
- Simultaneous ovr set and ovr clear: set wins.
- A DATA write in the cycle busy is first sampled 0 is accepted.
- irq_o = irq_en & rxv, registered, level.
- wb_rst during a transfer: next cycle all reset values, transfer aborted, rxv=0.

Decomposition:
- Shared header wb_spi_defs.vh: register offsets, CTRL/STATUS bit positions, FSM state encodings (IDLE/SHIFT/GUARD).
- Sub-module spi_shift_engine: FSM, divider, edge counter, shifter. Handshake is start/busy/done plus tx and rx bytes.
- Top module: Wishbone decode, registers, irq.

Test Plan:
- Reset -> CTRL reads 0x0004_000B; STATUS 0x0; SCK=0; SSEL=1; ack never spontaneous.
- Mode 0, div=0, MISO looped to MOSI, write 0xA5:
  - 8 rising edges; MOSI sampled on rising edges = 1,0,1,0,0,1,0,1.
  - busy for 17 cycles; STATUS=0x2; DATA reads 0xA5; STATUS then 0x0.
- Mode 3 (CTRL=0x0007_0002), bench slave returns 0x3C:
  - SCK idles high; busy for 51 cycles; RX=0x3C.
  - Slave sees 0x5A when 0x5A is written.
- Write DATA 0x11 mid-transfer of 0x22 -> ovr=1, wire shows only 0x22. Then write STATUS 0x4 -> ovr=0.
- CTRL irq_en=1, complete transfer -> irq_o=1 the cycle after rxv sets; DATA read -> irq_o=0 one cycle later.
- Assert wb_rst at edge e=5 of a div=3 transfer -> next cycle SCK=0, SSEL=1, busy=0, rxv=0. A new transfer afterwards completes normally.

Source files
------------

// File: rtl/wb_spi_master_pkg.sv
// Shared definitions for the Wishbone SPI master.
// Contents: register offsets (word index taken from wb_adr_i[3:2]), CTRL and
// STATUS bit positions, the shift-engine state encoding, and a helper that
// expands Wishbone byte-lane selects into a 32-bit bit mask.
package wb_spi_master_pkg;

  // Register word offsets (byte address bits [3:2])
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // CTRL bit positions; the divider occupies [DIV_WIDTH-1:0]
  localparam int CTRL_CPOL_BIT  = 16;
  localparam int CTRL_CPHA_BIT  = 17;
  localparam int CTRL_SSEL_BIT  = 18;
  localparam int CTRL_IRQEN_BIT = 19;

  // STATUS bit positions
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_RXV_BIT  = 1;
  localparam int STAT_OVR_BIT  = 2;

  // Shift engine states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GUARD = 2'd2
  } spi_state_t;

  // Expand the four byte-lane enables into a per-bit write mask
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_spi_master_shift_engine.sv
// spi_shift_engine: 8-bit MSB-first SPI shifter with its own half-period
// divider, SCK edge counter and IDLE/SHIFT/GUARD state machine.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start           one-cycle request; accepted only while idle
//   tx              byte to send, captured together with start
//   div             half-period divider (half-period = div+1 clocks)
//   cpol, cpha      SPI mode bits, captured together with start
//   idle_cpol       SCK level to drive while idle
//   miso            serial input
//   busy            high from the cycle after start until completion
//   done            one-cycle pulse on the GUARD -> IDLE transition
//   rx              received byte, complete when done pulses
//   sck, mosi       serial clock and serial output
module spi_shift_engine
  import wb_spi_master_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           tx,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic                 idle_cpol,
  input  logic                 miso,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           rx,
  output logic                 sck,
  output logic                 mosi
);

  spi_state_t           state_q;
  spi_state_t           state_d;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [DIV_WIDTH-1:0] div_sh;
  logic                 cpha_sh;
  logic [3:0]           edge_idx;
  logic [7:0]           tx_sh;
  logic [7:0]           rx_sh;
  logic                 tick;
  logic                 last_edge;

  // tick marks the final clock of each half-period
  assign tick      = (div_cnt == div_sh);
  assign last_edge = (edge_idx == 4'd15);
  assign busy      = (state_q != ST_IDLE);
  assign rx        = rx_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick && last_edge) begin
          state_d = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (tick) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath. The captured SCK level at start acts as the cpol shadow: after
  // sixteen toggles it returns to that level by construction. An edge whose
  // index parity equals cpha samples MISO, the other parity presents the
  // next MOSI bit (never after the final edge).
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      div_sh   <= '0;
      cpha_sh  <= 1'b0;
      edge_idx <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          div_cnt  <= '0;
          edge_idx <= '0;
          sck      <= idle_cpol;
          if (start) begin
            div_sh  <= div;
            cpha_sh <= cpha;
            sck     <= cpol;
            rx_sh   <= '0;
            if (cpha) begin
              tx_sh <= tx;
            end else begin
              mosi  <= tx[7];
              tx_sh <= {tx[6:0], 1'b0};
            end
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            div_cnt  <= '0;
            sck      <= ~sck;
            edge_idx <= edge_idx + 4'd1;
            if (edge_idx[0] == cpha_sh) begin
              rx_sh <= {rx_sh[6:0], miso};
            end else if (!last_edge) begin
              mosi  <= tx_sh[7];
              tx_sh <= {tx_sh[6:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
          end
        end
        ST_GUARD: begin
          if (tick) begin
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
          end
        end
        default: begin
          div_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/wb_spi_master.sv
// wb_spi_master: Wishbone classic slave SPI master, 8-bit frames, modes 0-3.
// Registers: 0x0 DATA, 0x4 CTRL, 0x8 STATUS, 0xC reserved (reads 0).
// Ports:
//   wb_clk, wb_rst         clock, synchronous active-high reset
//   wb_adr_i[3:0]          byte address, only [3:2] decoded
//   wb_dat_i/wb_dat_o      32-bit write / read data
//   wb_sel_i[3:0]          byte-lane enables
//   wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o   classic handshake, no wait states
//   spi_sck_o, spi_mosi_o, spi_miso_i       SPI pins
//   spi_ssel_o             slave select, level taken directly from CTRL.ssel
//   irq_o                  level interrupt, irq_en & rxv registered
module wb_spi_master
  import wb_spi_master_pkg::*;
#(
  parameter int          DIV_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 11
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        spi_sck_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i,
  output logic        spi_ssel_o,
  output logic        irq_o
);

  logic [DIV_WIDTH-1:0] ctrl_div;
  logic                 ctrl_cpol;
  logic                 ctrl_cpha;
  logic                 ctrl_ssel;
  logic                 ctrl_irq_en;
  logic [7:0]           rx_reg;
  logic                 rxv;
  logic                 ovr;
  logic                 busy;
  logic                 done;
  logic [7:0]           eng_rx;

  logic        access;
  logic        wr;
  logic        rd;
  logic [1:0]  reg_sel;
  logic        data_wr;
  logic        data_rd;
  logic        start;
  logic        ovr_set;
  logic        ovr_clr;
  logic        ctrl_wr;
  logic [31:0] ctrl_word;
  logic [31:0] ctrl_next;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign access  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr      = access & wb_we_i;
  assign rd      = access & ~wb_we_i;
  assign reg_sel = wb_adr_i[3:2];

  // DATA needs lane 0 enabled; a write while busy only flags an overrun
  assign data_wr = wr && (reg_sel == REG_DATA) && wb_sel_i[0];
  assign data_rd = rd && (reg_sel == REG_DATA);
  assign start   = data_wr & ~busy;
  assign ovr_set = data_wr & busy;
  assign ovr_clr = wr && (reg_sel == REG_STATUS) && wb_sel_i[0]
                   && wb_dat_i[STAT_OVR_BIT];
  assign ctrl_wr = wr && (reg_sel == REG_CTRL);

  assign unused_bits = ^{wb_adr_i[1:0], ctrl_next[31:20]};

  // Packed view of CTRL, and the value it will hold after this cycle. The
  // engine takes its idle SCK level from the next value so that SCK follows
  // a cpol write on the same edge as the register itself.
  always_comb begin
    ctrl_word                  = '0;
    ctrl_word[DIV_WIDTH-1:0]   = ctrl_div;
    ctrl_word[CTRL_CPOL_BIT]   = ctrl_cpol;
    ctrl_word[CTRL_CPHA_BIT]   = ctrl_cpha;
    ctrl_word[CTRL_SSEL_BIT]   = ctrl_ssel;
    ctrl_word[CTRL_IRQEN_BIT]  = ctrl_irq_en;
    ctrl_next = ctrl_word;
    if (ctrl_wr) begin
      ctrl_next = (ctrl_word & ~lane_mask(wb_sel_i))
                | (wb_dat_i & lane_mask(wb_sel_i));
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_DATA:   rd_data[7:0] = rx_reg;
      REG_CTRL:   rd_data      = ctrl_word;
      REG_STATUS: rd_data[2:0] = {ovr, rxv, busy};
      default:    rd_data      = '0;
    endcase
  end

  // Bus handshake, registers and interrupt. Completion setting rxv takes
  // priority over a simultaneous DATA read clearing it, and an overrun set
  // takes priority over a simultaneous clear.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= '0;
      ctrl_div    <= DIV_WIDTH'(DEFAULT_DIV);
      ctrl_cpol   <= 1'b0;
      ctrl_cpha   <= 1'b0;
      ctrl_ssel   <= 1'b1;
      ctrl_irq_en <= 1'b0;
      rx_reg      <= '0;
      rxv         <= 1'b0;
      ovr         <= 1'b0;
      irq_o       <= 1'b0;
    end else begin
      wb_ack_o <= access;
      if (rd) begin
        wb_dat_o <= rd_data;
      end
      ctrl_div    <= ctrl_next[DIV_WIDTH-1:0];
      ctrl_cpol   <= ctrl_next[CTRL_CPOL_BIT];
      ctrl_cpha   <= ctrl_next[CTRL_CPHA_BIT];
      ctrl_ssel   <= ctrl_next[CTRL_SSEL_BIT];
      ctrl_irq_en <= ctrl_next[CTRL_IRQEN_BIT];
      if (done) begin
        rx_reg <= eng_rx;
        rxv    <= 1'b1;
      end else if (data_rd) begin
        rxv <= 1'b0;
      end
      ovr   <= ovr_set | (ovr & ~ovr_clr);
      irq_o <= ctrl_irq_en & rxv;
    end
  end

  assign spi_ssel_o = ctrl_ssel;

  spi_shift_engine #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_engine (
    .clk       (wb_clk),
    .rst       (wb_rst),
    .start     (start),
    .tx        (wb_dat_i[7:0]),
    .div       (ctrl_div),
    .cpol      (ctrl_cpol),
    .cpha      (ctrl_cpha),
    .idle_cpol (ctrl_next[CTRL_CPOL_BIT]),
    .miso      (spi_miso_i),
    .busy      (busy),
    .done      (done),
    .rx        (eng_rx),
    .sck       (spi_sck_o),
    .mosi      (spi_mosi_o)
  );

endmodule

// File: tb/tb_wb_spi_master.sv
// Testbench for wb_spi_master. Bus reads push their expected data into a
// queue; a monitor pops and compares on every wb_ack_o. A behavioural SPI
// slave model captures MOSI and returns a preset byte (or loops MOSI back).
module tb_wb_spi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [31:0] dat_r;
  logic        ack;
  logic        sck;
  logic        mosi;
  logic        miso;
  logic        ssel;
  logic        irq;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] exp_q[$];
  bit          chk_q[$];
  string       name_q[$];

  // Slave model state
  logic       slv_cpol = 1'b0;
  logic       slv_cpha = 1'b0;
  logic       slv_loop = 1'b0;
  logic [7:0] slv_tx   = 8'h00;
  logic [7:0] slv_rx   = 8'h00;
  logic       slv_miso = 1'b0;
  int         slv_idx  = 0;
  int         rise_cnt = 0;

  assign miso = slv_loop ? mosi : slv_miso;

  always #5 clk = ~clk;

  wb_spi_master dut (
    .wb_clk     (clk),
    .wb_rst     (rst),
    .wb_adr_i   (adr),
    .wb_dat_i   (dat_w),
    .wb_sel_i   (sel),
    .wb_we_i    (we),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_dat_o   (dat_r),
    .wb_ack_o   (ack),
    .spi_sck_o  (sck),
    .spi_mosi_o (mosi),
    .spi_miso_i (miso),
    .spi_ssel_o (ssel),
    .irq_o      (irq)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every acknowledge consumes one queued access
  always @(negedge clk) begin
    if (ack) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_ack", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        bit          c;
        string       n;
        e = exp_q.pop_front();
        c = chk_q.pop_front();
        n = name_q.pop_front();
        if (c) checkOutput(n, dat_r, e);
      end
    end
  end

  // SPI slave: leading edge moves SCK away from cpol
  always @(posedge sck or negedge sck) begin
    if (sck) rise_cnt++;
    if (sck != slv_cpol) begin
      if (!slv_cpha) begin
        slv_rx = {slv_rx[6:0], mosi};
      end else begin
        if (slv_idx < 8) slv_miso = slv_tx[7 - slv_idx];
        slv_idx++;
      end
    end else begin
      if (!slv_cpha) begin
        slv_idx++;
        if (slv_idx < 8) slv_miso = slv_tx[7 - slv_idx];
      end else begin
        slv_rx = {slv_rx[6:0], mosi};
      end
    end
  end

  task automatic slavePrep(input logic cp, input logic ch, input logic [7:0] t,
                           input logic lp);
    slv_cpol = cp;
    slv_cpha = ch;
    slv_tx   = t;
    slv_loop = lp;
    slv_rx   = 8'h00;
    slv_idx  = 0;
    slv_miso = t[7];
    rise_cnt = 0;
  endtask

  // One bus access; returns #1 after the sampling edge
  task automatic applyStimulus(input logic [3:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic w,
                               input logic [31:0] expd, input string name);
    @(posedge clk);
    #1;
    exp_q.push_back(expd);
    chk_q.push_back(!w);
    name_q.push_back(name);
    adr = a; dat_w = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    checkOutput({name, "_ack"}, {31'd0, ack}, 32'd1);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input string name);
    applyStimulus(a, d, 4'hF, 1'b1, 32'd0, name);
  endtask

  task automatic rdx(input logic [3:0] a, input logic [31:0] expd, input string name);
    applyStimulus(a, 32'd0, 4'hF, 1'b0, expd, name);
  endtask

  // Count cycles busy remains high, starting from the current cycle
  task automatic waitIdle(input int limit, output int n);
    n = 0;
    while (dut.busy && n < limit) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int acks;
    int toggles;
    int cycles;
    logic prev;

    rst = 1'b1; adr = '0; dat_w = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    checkOutput("rst_sck", {31'd0, sck}, 32'd0);
    checkOutput("rst_ssel", {31'd0, ssel}, 32'd1);
    checkOutput("rst_mosi", {31'd0, mosi}, 32'd0);
    checkOutput("rst_irq", {31'd0, irq}, 32'd0);
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    checkOutput("no_spont_ack", acks, 0);
    rdx(4'h4, 32'h0004_000B, "rst_ctrl");
    rdx(4'h8, 32'h0000_0000, "rst_status");
    rdx(4'h0, 32'h0000_0000, "rst_data");
    rdx(4'hC, 32'h0000_0000, "rst_rsvd");

    // Mode 0, div=0, MISO looped to MOSI
    wr(4'h4, 32'h0000_0000, "m0_ctrl");
    checkOutput("m0_ssel_low", {31'd0, ssel}, 32'd0);
    slavePrep(1'b0, 1'b0, 8'h00, 1'b1);
    wr(4'h0, 32'h0000_00A5, "m0_data");
    waitIdle(100, n);
    checkOutput("m0_busy_cycles", n, 17);
    checkOutput("m0_rise_edges", rise_cnt, 8);
    checkOutput("m0_mosi_bits", {24'd0, slv_rx}, 32'h0000_00A5);
    rdx(4'h8, 32'h0000_0002, "m0_status_rxv");
    rdx(4'h0, 32'h0000_00A5, "m0_rx");
    rdx(4'h8, 32'h0000_0000, "m0_status_clr");
    wr(4'hC, 32'hFFFF_FFFF, "rsvd_wr");
    rdx(4'hC, 32'h0000_0000, "rsvd_rd");

    // DATA write without lane 0 must not start a transfer
    applyStimulus(4'h0, 32'h0000_0055, 4'b1110, 1'b1, 32'd0, "nolane_wr");
    checkOutput("nolane_idle", {31'd0, dut.busy}, 32'd0);

    // Mode 3, div=2
    wr(4'h4, 32'h0007_0002, "m3_ctrl");
    checkOutput("m3_sck_idle_high", {31'd0, sck}, 32'd1);
    slavePrep(1'b1, 1'b1, 8'h3C, 1'b0);
    wr(4'h0, 32'h0000_005A, "m3_data");
    waitIdle(200, n);
    checkOutput("m3_busy_cycles", n, 51);
    checkOutput("m3_slave_rx", {24'd0, slv_rx}, 32'h0000_005A);
    checkOutput("m3_sck_end_high", {31'd0, sck}, 32'd1);
    rdx(4'h0, 32'h0000_003C, "m3_rx");
    rdx(4'h4, 32'h0007_0002, "m3_ctrl_rd");

    // Overrun: second DATA write two cycles into a div=3 transfer
    wr(4'h4, 32'h0000_0003, "ovr_ctrl");
    slavePrep(1'b0, 1'b0, 8'h96, 1'b0);
    wr(4'h0, 32'h0000_0022, "ovr_data1");
    wr(4'h0, 32'h0000_0011, "ovr_data2");
    waitIdle(200, n);
    checkOutput("ovr_busy_cycles", n, 66);
    checkOutput("ovr_wire_byte", {24'd0, slv_rx}, 32'h0000_0022);
    rdx(4'h8, 32'h0000_0006, "ovr_status_set");
    wr(4'h8, 32'h0000_0004, "ovr_clear");
    rdx(4'h8, 32'h0000_0002, "ovr_status_clr");
    rdx(4'h0, 32'h0000_0096, "ovr_rx");
    rdx(4'h8, 32'h0000_0000, "ovr_status_final");

    // Interrupt, div=1
    wr(4'h4, 32'h0008_0001, "irq_ctrl");
    slavePrep(1'b0, 1'b0, 8'hC3, 1'b0);
    wr(4'h0, 32'h0000_0081, "irq_data");
    waitIdle(200, n);
    checkOutput("irq_busy_cycles", n, 34);
    checkOutput("irq_low_at_rxv", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("irq_high", {31'd0, irq}, 32'd1);
    checkOutput("irq_slave_rx", {24'd0, slv_rx}, 32'h0000_0081);
    rdx(4'h0, 32'h0000_00C3, "irq_rx");
    checkOutput("irq_still_high", {31'd0, irq}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("irq_cleared", {31'd0, irq}, 32'd0);

    // Reset at edge e=5 of a div=3 transfer
    wr(4'h4, 32'h0000_0003, "rst_mid_ctrl");
    slavePrep(1'b0, 1'b0, 8'h00, 1'b0);
    wr(4'h0, 32'h0000_00F0, "rst_mid_data");
    prev = sck;
    toggles = 0;
    cycles = 0;
    while (toggles < 6 && cycles < 200) begin
      @(posedge clk);
      #1;
      if (sck != prev) begin
        toggles++;
        prev = sck;
      end
      cycles++;
    end
    checkOutput("rst_mid_edges_seen", toggles, 6);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_mid_sck", {31'd0, sck}, 32'd0);
    checkOutput("rst_mid_ssel", {31'd0, ssel}, 32'd1);
    checkOutput("rst_mid_mosi", {31'd0, mosi}, 32'd0);
    checkOutput("rst_mid_busy", {31'd0, dut.busy}, 32'd0);
    rdx(4'h8, 32'h0000_0000, "rst_mid_status");
    rdx(4'h4, 32'h0004_000B, "rst_mid_ctrl_rd");

    // Fresh transfer at the default divider
    slavePrep(1'b0, 1'b0, 8'h5A, 1'b0);
    wr(4'h0, 32'h0000_003C, "post_rst_data");
    waitIdle(400, n);
    checkOutput("post_rst_busy_cycles", n, 204);
    checkOutput("post_rst_slave_rx", {24'd0, slv_rx}, 32'h0000_003C);
    rdx(4'h0, 32'h0000_005A, "post_rst_rx");
    rdx(4'h8, 32'h0000_0000, "post_rst_status");

    repeat (3) @(posedge clk);
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
